aes_spi_ctrl: RTL and testbench

Slave-side SPI transaction sequencer for the AES core. It deserializes a 128-bit block and a 128/192/256-bit key from SIMO on clk while CSS is low, then starts the AES core with a one-cycle pulse and waits for its done flag. It holds the result and serializes it on SOMI during a later read frame. It replaces ad-hoc bit counting in the SPI slave with an explicit FSM and a start/done handshake.

---
 rtl/aes_spi_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_aes_spi_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_ctrl.sv
// SPI slave sequencer for the AES core: loads block + key, starts the core, returns the result.
// Optional WAIT-state watchdog is compiled in when AES_TIMEOUT_EN is defined.
module aes_spi_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         CSS,
    input  logic         SIMO,
    input  logic         mode,
    input  logic [1:0]   size,
    output logic         SOMI,
    output logic         aes_start,
    output logic         aes_mode,
    output logic [1:0]   aes_size,
    output logic [127:0] aes_msg,
    output logic [255:0] aes_key,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic         busy,
    output logic         rdy,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_MSG,
        S_RX_KEY,
        S_DISCARD,
        S_START,
        S_WAIT,
        S_HOLD,
        S_TX
    } state_t;

    state_t         state_reg, state_next;
    logic [8:0]     cnt_reg, cnt_next;
    logic           mode_reg, mode_next;
    logic [1:0]     size_reg, size_next;
    logic [127:0]   msg_reg, msg_next;
    logic [255:0]   key_reg, key_next;
    logic [127:0]   result_reg, result_next;
    logic           rdy_reg, rdy_next;
    logic           err_reg, err_next;
    logic           somi_reg, somi_next;
    logic [8:0]     key_len;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef AES_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
`endif

    always_comb begin
        case (size_reg)
            2'b00:   key_len = 9'd128;
            2'b01:   key_len = 9'd192;
            default: key_len = 9'd256;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mode_next   = mode_reg;
        size_next   = size_reg;
        msg_next    = msg_reg;
        key_next    = key_reg;
        result_next = result_reg;
        rdy_next    = rdy_reg;
        err_next    = 1'b0;
        somi_next   = 1'b0;
`ifdef AES_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!CSS && !rdy_reg) begin
                    mode_next = mode;
                    size_next = size;
                    if (size == 2'b11) begin
                        err_next   = 1'b1;
                        state_next = S_DISCARD;
                    end else begin
                        // Clearing the key here keeps bits above Nk*32 zero for short keys.
                        key_next    = '0;
                        msg_next[0] = SIMO;
                        cnt_next    = 9'd1;
                        state_next  = S_RX_MSG;
                    end
                end
            end
            S_RX_MSG: begin
                if (CSS) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    msg_next[cnt_reg[6:0]] = SIMO;
                    if (cnt_reg == 9'd127) begin
                        cnt_next   = 9'd0;
                        state_next = S_RX_KEY;
                    end else begin
                        cnt_next = cnt_reg + 9'd1;
                    end
                end
            end
            S_RX_KEY: begin
                if (CSS) begin
                    if (cnt_reg == key_len) begin
                        state_next = S_START;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end else if (cnt_reg < key_len) begin
                    key_next[cnt_reg[7:0]] = SIMO;
                    cnt_next = cnt_reg + 9'd1;
                end
            end
            S_DISCARD: begin
                if (CSS) begin
                    state_next = S_IDLE;
                end
            end
            S_START: begin
                // aes_done in this cycle is deliberately not looked at.
                state_next = S_WAIT;
`ifdef AES_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
            end
            S_WAIT: begin
                if (aes_done) begin
                    result_next = aes_result;
                    rdy_next    = 1'b1;
                    state_next  = S_HOLD;
                end
`ifdef AES_TIMEOUT_EN
                else if (wait_cnt_reg == WCW'(TIMEOUT_CYCLES - 1)) begin
                    err_next   = 1'b1;
                    rdy_next   = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (!CSS) begin
                    somi_next  = result_reg[0];
                    cnt_next   = 9'd1;
                    state_next = S_TX;
                end
            end
            S_TX: begin
                if (CSS) begin
                    // A frame that already shifted all 128 bits counts as a complete read.
                    if (cnt_reg == 9'd128) begin
                        rdy_next   = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_HOLD;
                    end
                end else if (cnt_reg == 9'd128) begin
                    rdy_next = 1'b0;
                end else begin
                    somi_next = result_reg[cnt_reg[6:0]];
                    cnt_next  = cnt_reg + 9'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            mode_reg   <= 1'b0;
            size_reg   <= 2'b00;
            msg_reg    <= '0;
            key_reg    <= '0;
            result_reg <= '0;
            rdy_reg    <= 1'b0;
            err_reg    <= 1'b0;
            somi_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mode_reg   <= mode_next;
            size_reg   <= size_next;
            msg_reg    <= msg_next;
            key_reg    <= key_next;
            result_reg <= result_next;
            rdy_reg    <= rdy_next;
            err_reg    <= err_next;
            somi_reg   <= somi_next;
        end
    end

`ifdef AES_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    assign SOMI      = somi_reg;
    assign aes_start = (state_reg == S_START);
    assign aes_mode  = mode_reg;
    assign aes_size  = size_reg;
    assign aes_msg   = msg_reg;
    assign aes_key   = key_reg;
    assign busy      = (state_reg == S_RX_MSG) || (state_reg == S_RX_KEY) ||
                       (state_reg == S_START)  || (state_reg == S_WAIT);
    assign rdy       = rdy_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Randomised self-checking bench for aes_spi_ctrl; a frame-level model predicts msg/key/result.
module tb_aes_spi_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         CSS;
    logic         SIMO;
    logic         mode;
    logic [1:0]   size;
    logic         SOMI;
    logic         aes_start;
    logic         aes_mode;
    logic [1:0]   aes_size;
    logic [127:0] aes_msg;
    logic [255:0] aes_key;
    logic         aes_done;
    logic [127:0] aes_result;
    logic         busy;
    logic         rdy;
    logic         err;

    always #5 clk = ~clk;

    aes_spi_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .CSS        (CSS),
        .SIMO       (SIMO),
        .mode       (mode),
        .size       (size),
        .SOMI       (SOMI),
        .aes_start  (aes_start),
        .aes_mode   (aes_mode),
        .aes_size   (aes_size),
        .aes_msg    (aes_msg),
        .aes_key    (aes_key),
        .aes_done   (aes_done),
        .aes_result (aes_result),
        .busy       (busy),
        .rdy        (rdy),
        .err        (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_errp = 0;
    int busy_lo = 0;
    int first_err_idx = -1;
    int txn_id = 0;

    always @(negedge clk) begin
        if (aes_start === 1'b1) n_start++;
        if (err === 1'b1) n_errp++;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int key_bits(input logic [1:0] s);
        return (s == 2'b00) ? 128 : (s == 2'b01) ? 192 : 256;
    endfunction

    // Reference: key is the Nk*32 bits that follow the 128 message bits, zero above.
    function automatic logic [255:0] ref_key(input logic [383:0] bits, input logic [1:0] s);
        logic [255:0] k;
        k = '0;
        for (int i = 0; i < key_bits(s); i++) k[i] = bits[128 + i];
        return k;
    endfunction

    task automatic send_frame(input logic [383:0] bits, input int nbits, input logic m, input logic [1:0] s);
        mode = m;
        size = s;
        first_err_idx = -1;
        for (int i = 0; i < nbits; i++) begin
            CSS  = 1'b0;
            SIMO = bits[i];
            tick();
            if (busy !== 1'b1) busy_lo++;
            if (err === 1'b1 && first_err_idx < 0) first_err_idx = i;
        end
        CSS  = 1'b1;
        SIMO = 1'b0;
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (aes_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic write_txn(input logic [127:0] msg, input logic [255:0] key, input logic m,
                             input logic [1:0] s, input int extra, input bit stray,
                             input int delay, input logic [127:0] result, output bit ok);
        logic [383:0] bits;
        logic [255:0] exp_key;
        int s0;
        int somi_hi;
        bit seen;
        bits    = {key, msg};
        exp_key = ref_key(bits, s);
        s0      = n_start;
        busy_lo = 0;
        somi_hi = 0;
        send_frame(bits, 128 + key_bits(s) + extra, m, s);
        wait_start(seen);
        check("start_seen", seen, 1'b1);
        ok = seen;
        if (seen) begin
            check("start_msg", aes_msg, msg);
            check("start_key", aes_key, exp_key);
            check("start_mode", aes_mode, m);
            check("start_size", aes_size, s);
            if (stray) begin
                aes_done   = 1'b1;
                aes_result = ~result;
                tick();
                aes_done   = 1'b0;
                check("stray_done_rdy", rdy, 1'b0);
            end else begin
                tick();
            end
            check("start_width", aes_start, 1'b0);
            for (int c = 0; c < delay; c++) begin
                CSS  = 1'($urandom_range(0, 1));
                SIMO = 1'($urandom_range(0, 1));
                tick();
                if (SOMI !== 1'b0) somi_hi++;
                if (busy !== 1'b1) busy_lo++;
            end
            CSS = 1'b1;
            check("msg_stable", aes_msg, msg);
            check("key_stable", aes_key, exp_key);
            aes_done   = 1'b1;
            aes_result = result;
            tick();
            aes_done   = 1'b0;
            aes_result = {$urandom, $urandom, $urandom, $urandom};
            check("rdy_set", rdy, 1'b1);
            check("busy_after_done", busy, 1'b0);
            check("wait_somi_zero", somi_hi, 0);
            check("busy_low_cycles", busy_lo, 0);
            check("start_count", n_start - s0, 1);
        end
        $display("txn %0d: write size=%0d mode=%0d bits=%0d stray=%0d result=%h",
                 txn_id, s, m, 128 + key_bits(s) + extra, stray, result);
        txn_id++;
    endtask

    task automatic read_frame(input int nbits, output logic [128:0] got);
        got = '0;
        for (int k = 0; k < nbits; k++) begin
            CSS = 1'b0;
            tick();
            got[k] = SOMI;
        end
        CSS = 1'b1;
        tick();
        $display("txn %0d: read bits=%0d data=%h", txn_id, nbits, got[127:0]);
        txn_id++;
    endtask

    task automatic full_read(input logic [127:0] result, input int nbits);
        logic [128:0] got;
        read_frame(nbits, got);
        check("read_data", got[127:0], result);
        if (nbits > 128) check("read_tail_zero", got[128], 1'b0);
        check("read_rdy_clr", rdy, 1'b0);
        check("read_somi_idle", SOMI, 1'b0);
    endtask

    initial begin
        logic [127:0] msg;
        logic [255:0] key;
        logic [127:0] res;
        logic [383:0] bits;
        logic [128:0] got;
        bit ok;
        int s0;
        int e0;

        reset = 1'b0; CSS = 1'b1; SIMO = 1'b0; mode = 1'b0; size = 2'b00;
        aes_done = 1'b0; aes_result = '0;
        repeat (3) tick();
        check("rst_somi", SOMI, 1'b0);
        check("rst_start", aes_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdy", rdy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_msg", aes_msg, 128'h0);
        check("rst_key", aes_key, 256'h0);
        check("rst_mode_size", {aes_mode, aes_size}, 3'b000);
        reset = 1'b1;
        tick();

        // Known AES-128 encrypt vector
        msg = 128'h00112233445566778899aabbccddeeff;
        key = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
        res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        write_txn(msg, key, 1'b0, 2'b00, 0, 1'b0, 5, res, ok);
        if (ok) full_read(res, 128);

        // AES-256 decrypt, random data
        msg = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        res = {$urandom, $urandom, $urandom, $urandom};
        write_txn(msg, key, 1'b1, 2'b10, 0, 1'b1, 7, res, ok);
        if (ok) full_read(res, 128);

        // Short frame: 200 of 256 bits
        msg = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bits = {key, msg};
        s0 = n_start; e0 = n_errp;
        send_frame(bits, 200, 1'b0, 2'b00);
        tick();
        check("short_err_pulse", err, 1'b1);
        check("short_busy", busy, 1'b0);
        tick();
        check("short_err_width", err, 1'b0);
        repeat (4) tick();
        check("short_no_start", n_start - s0, 0);
        check("short_err_count", n_errp - e0, 1);
        check("short_msg_kept", aes_msg, msg);
        check("short_key_partial", aes_key[71:0], key[71:0]);
        $display("txn %0d: short frame 200 bits", txn_id);
        txn_id++;

        // Reserved size, followed by a normal frame
        s0 = n_start; e0 = n_errp;
        send_frame(bits, 256, 1'b0, 2'b11);
        repeat (4) tick();
        check("rsv_err_at_first_bit", first_err_idx, 0);
        check("rsv_err_count", n_errp - e0, 1);
        check("rsv_no_start", n_start - s0, 0);
        check("rsv_busy", busy, 1'b0);
        $display("txn %0d: reserved size frame", txn_id);
        txn_id++;
        res = {$urandom, $urandom, $urandom, $urandom};
        write_txn(msg, key, 1'b0, 2'b01, 3, 1'b0, 2, res, ok);
        if (ok) full_read(res, 128);

        // Aborted read after 40 bits, then full read from bit 0
        msg = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        res = {$urandom, $urandom, $urandom, $urandom};
        write_txn(msg, key, 1'b1, 2'b00, 0, 1'b0, 3, res, ok);
        if (ok) begin
            read_frame(40, got);
            check("abort_data", got[39:0], res[39:0]);
            check("abort_rdy_kept", rdy, 1'b1);
            check("abort_somi_zero", SOMI, 1'b0);
            full_read(res, 128);
        end

        // Asynchronous reset during WAIT
        s0 = n_start;
        bits = {key, msg};
        send_frame(bits, 256, 1'b1, 2'b00);
        wait_start(ok);
        check("rw_start_seen", ok, 1'b1);
        tick();
        tick();
        check("rw_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rw_outputs_zero", {SOMI, aes_start, aes_mode, aes_size, busy, rdy, err}, 8'h00);
        check("rw_msg_zero", aes_msg, 128'h0);
        check("rw_key_zero", aes_key, 256'h0);
        tick();
        reset = 1'b1;
        aes_done = 1'b1;
        aes_result = {$urandom, $urandom, $urandom, $urandom};
        tick();
        aes_done = 1'b0;
        repeat (3) tick();
        check("rw_no_rdy", rdy, 1'b0);
        check("rw_single_start", n_start - s0, 1);
        $display("txn %0d: reset during wait", txn_id);
        txn_id++;

        // Randomised transactions
        for (int t = 0; t < 6; t++) begin
            logic [1:0] s;
            logic m;
            s   = 2'($urandom_range(0, 2));
            m   = 1'($urandom_range(0, 1));
            msg = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            res = {$urandom, $urandom, $urandom, $urandom};
            write_txn(msg, key, m, s, $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                      $urandom_range(1, 12), res, ok);
            if (ok) full_read(res, 128 + $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
